// File: rtl/lf32_pkg.sv
// Shared types and the prefix operator for the 32-bit Ladner-Fischer adder/subtractor family.
package lf32_pkg;

   localparam int LF32_WIDTH  = 32;
   localparam int LF32_LEVELS = 5;

   typedef logic [31:0] lf32_word_t;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // (G,P) o (G',P') with the more significant group on the left.
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/lf32_prefix_level.sv
// One Ladner-Fischer prefix level: bits in the upper half of each 2^(LEVEL+1) block
// absorb the top node of the lower half. Purely combinational.
module lf32_prefix_level
   import lf32_pkg::*;
#(
   parameter int LEVEL = 0
)
(
   input  gp_t [LF32_WIDTH-1:0] prev,
   output gp_t [LF32_WIDTH-1:0] next
);

   for (genvar i = 0; i < LF32_WIDTH; i++) begin : g_bit
      if (((i >> LEVEL) & 1) == 1) begin : g_op
         localparam int SRC = ((i >> (LEVEL + 1)) << (LEVEL + 1)) + (1 << LEVEL) - 1;
         assign next[i] = gp_combine(prev[i], prev[SRC]);
      end else begin : g_pass
         assign next[i] = prev[i];
      end
   end

endmodule

// File: rtl/lf32_sub_pipe.sv
// Two-stage pipelined 32-bit prefix subtractor, diff = a - b with borrow; 2-cycle latency.
// Valid/ready both sides, full throughput; in_ready follows out_ready combinationally.
// LF32_SUB_OVF_EN adds the registered signed-overflow output ovf.
module lf32_sub_pipe
   import lf32_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SPLIT_LEVEL = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef LF32_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   if (WIDTH != LF32_WIDTH) begin : g_bad_width
      $error("lf32_sub_pipe: only WIDTH=32 is supported");
   end
   if (SPLIT_LEVEL < 0 || SPLIT_LEVEL > LF32_LEVELS) begin : g_bad_split
      $error("lf32_sub_pipe: SPLIT_LEVEL must be within 0..5");
   end

   localparam int S2_LEVELS = LF32_LEVELS - SPLIT_LEVEL;

   logic s1_v, s2_v;
   logic s1_adv, s2_adv;

   assign s2_adv    = ~s2_v | out_ready;
   assign s1_adv    = ~s1_v | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_v;

   // ---------------- stage 1: per-bit terms and the first prefix levels
   lf32_word_t              p0;
   gp_t [LF32_WIDTH-1:0]    gp0;
   gp_t [LF32_WIDTH-1:0]    na [SPLIT_LEVEL+1];

   assign p0 = a ^ ~b;

   always_comb begin
      for (int i = 0; i < LF32_WIDTH; i++) begin
         gp0[i].g = a[i] & ~b[i];
         gp0[i].p = p0[i];
      end
      // the +1 of a + ~b + 1 folds into the bit-0 group generate
      gp0[0].g = (a[0] & ~b[0]) | p0[0];
   end

   assign na[0] = gp0;

   for (genvar l = 0; l < SPLIT_LEVEL; l++) begin : g_s1_lvl
      lf32_prefix_level #(.LEVEL(l)) u_lvl (
         .prev (na[l]),
         .next (na[l+1])
      );
   end

   gp_t [LF32_WIDTH-1:0] s1_gp;
   lf32_word_t           s1_p;
`ifdef LF32_SUB_OVF_EN
   logic                 s1_a31, s1_b31;
`endif

   always_ff @(posedge clk) begin
      if (s1_adv) begin
         s1_gp <= na[SPLIT_LEVEL];
         s1_p  <= p0;
`ifdef LF32_SUB_OVF_EN
         s1_a31 <= a[WIDTH-1];
         s1_b31 <= b[WIDTH-1];
`endif
      end
   end

   // ---------------- stage 2: remaining levels, sum and flags
   gp_t [LF32_WIDTH-1:0] nb [S2_LEVELS+1];
   lf32_word_t           carry;
   lf32_word_t           diff_nxt;
   logic                 borrow_nxt;
   logic                 unused_final_p;

   assign nb[0] = s1_gp;

   for (genvar k = 0; k < S2_LEVELS; k++) begin : g_s2_lvl
      lf32_prefix_level #(.LEVEL(SPLIT_LEVEL + k)) u_lvl (
         .prev (nb[k]),
         .next (nb[k+1])
      );
   end

   always_comb begin
      carry          = '0;
      unused_final_p = 1'b0;
      for (int i = 0; i < LF32_WIDTH; i++) begin
         carry[i]       = nb[S2_LEVELS][i].g;
         unused_final_p = unused_final_p ^ nb[S2_LEVELS][i].p;
      end
   end

   assign diff_nxt   = s1_p ^ {carry[LF32_WIDTH-2:0], 1'b1};
   assign borrow_nxt = ~carry[LF32_WIDTH-1];

`ifdef LF32_SUB_OVF_EN
   logic ovf_nxt;
   assign ovf_nxt = (s1_a31 ^ s1_b31) & (s1_a31 ^ diff_nxt[LF32_WIDTH-1]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef LF32_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         if (s1_adv) begin
            s1_v <= in_valid;
         end
         if (s2_adv) begin
            s2_v   <= s1_v;
            diff   <= diff_nxt;
            borrow <= borrow_nxt;
`ifdef LF32_SUB_OVF_EN
            ovf    <= ovf_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lf32_sub_pipe.sv
// Randomized and directed bench for lf32_sub_pipe against an arithmetic reference queue.
module tb_lf32_sub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        borrow;
`ifdef LF32_SUB_OVF_EN
   logic        ovf;
`endif

   lf32_sub_pipe #(.WIDTH(32), .SPLIT_LEVEL(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef LF32_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          nout  = 0;
   int          cyc   = 0;
   bit          acc;
   bit          hold_v = 1'b0;
   logic [33:0] hold_val;
   logic [33:0] q[$];

   task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // {ovf, borrow, diff} straight from unsigned/signed arithmetic
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] d;
      logic        br;
      logic        of;
      d  = x - y;
      br = (x < y);
      of = 1'b0;
`ifdef LF32_SUB_OVF_EN
      begin
         longint sd;
         sd = longint'($signed(x)) - longint'($signed(y));
         of = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
`endif
      return {of, br, d};
   endfunction

   function automatic logic [33:0] observed();
`ifdef LF32_SUB_OVF_EN
      return {ovf, borrow, diff};
`else
      return {1'b0, borrow, diff};
`endif
   endfunction

   // One clock: drive after the falling edge, sample 1ns later, score transfers.
   task automatic tick(input bit r, input bit iv, input logic [31:0] av, input logic [31:0] bv,
                       input bit ordy);
      logic [33:0] exp_v;
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      a         = av;
      b         = bv;
      out_ready = ordy;
      #1;
      acc = 1'b0;
      if (hold_v) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_data", observed(), hold_val);
      end
      hold_v = 1'b0;
      if (r) begin
         q.delete();
      end else begin
         chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
         if (out_valid && ordy) begin
            if (q.size() == 0) begin
               chk("spurious_out", out_valid, 1'b0);
            end else begin
               exp_v = q.pop_front();
               chk("result", observed(), exp_v);
               nout++;
            end
         end else if (out_valid) begin
            hold_v   = 1'b1;
            hold_val = observed();
         end
         if (iv && in_ready) begin
            q.push_back(model(av, bv));
            acc = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 30) begin
         tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      logic [31:0] ta[4];
      logic [31:0] tb_[4];
      logic [31:0] td[4];
      logic        tbr[4];
      int          n0;
      int          i;
      int          accepted;
      int          budget;
      bit          pat[4];
      logic [31:0] ra, rb;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;

      // reset state
      tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_diff", diff, 32'h0);
      chk("rst_borrow", borrow, 1'b0);
`ifdef LF32_SUB_OVF_EN
      chk("rst_ovf", ovf, 1'b0);
`endif
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      // basic subtract and latency
      tick(1'b0, 1'b1, 32'h5, 32'h3, 1'b1);
      chk("basic_acc", acc, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("lat_c1_valid", out_valid, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("lat_c2_valid", out_valid, 1'b1);
      chk("basic_diff", diff, 32'h2);
      chk("basic_borrow", borrow, 1'b0);
      drain();

      // boundary table, streamed back to back
      ta[0] = 32'h0;        tb_[0] = 32'h1;        td[0] = 32'hFFFF_FFFF; tbr[0] = 1'b1;
      ta[1] = 32'h8000_0000; tb_[1] = 32'h1;       td[1] = 32'h7FFF_FFFF; tbr[1] = 1'b0;
      ta[2] = 32'h1234_5678; tb_[2] = 32'h1234_5678; td[2] = 32'h0;      tbr[2] = 1'b0;
      ta[3] = 32'hDEAD_BEEF; tb_[3] = 32'h0;       td[3] = 32'hDEAD_BEEF; tbr[3] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) tick(1'b0, 1'b1, ta[k], tb_[k], 1'b1);
         else       tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         if (k >= 2) begin
            chk("edge_valid", out_valid, 1'b1);
            chk("edge_diff", diff, td[k-2]);
            chk("edge_borrow", borrow, tbr[k-2]);
`ifdef LF32_SUB_OVF_EN
            chk("edge_ovf", ovf, (k == 3));
`endif
         end
      end
      drain();

      // stream of 8 with out_ready pattern 1,0,0,1
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      n0 = nout;
      i = 0;
      budget = 0;
      while (i < 8 && budget < 100) begin
         tick(1'b0, 1'b1, 32'(i) * 32'h1111_1111, 32'(i), pat[budget % 4]);
         if (acc) i++;
         budget++;
      end
      chk("stream_accepted", i, 8);
      drain();
      chk("stream_out", nout - n0, 8);

      // full-pipe swap
      tick(1'b0, 1'b1, 32'h100, 32'h1, 1'b0);
      tick(1'b0, 1'b1, 32'h200, 32'h2, 1'b0);
      tick(1'b0, 1'b1, 32'h300, 32'h3, 1'b1);
      chk("swap_acc", acc, 1'b1);
      chk("swap_valid", out_valid, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("swap_valid_next", out_valid, 1'b1);
      drain();

      // reset mid-operation
      tick(1'b0, 1'b1, 32'hAAAA, 32'h1, 1'b0);
      tick(1'b0, 1'b1, 32'hBBBB, 32'h2, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_diff", diff, 32'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick(1'b0, 1'b1, 32'h50, 32'h20, 1'b1);
      drain();

      // random compare
      accepted = 0;
      budget   = 0;
      while (accepted < 10000 && budget < 40000) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: rb = 32'h0;
            2: ra = 32'h0;
            3: begin ra = {1'b1, ra[30:0]}; rb = {1'b0, rb[30:0]}; end
            default: ;
         endcase
         tick(1'b0, ($urandom_range(0, 9) != 0), ra, rb, ($urandom_range(0, 3) != 0));
         if (acc) accepted++;
         budget++;
      end
      chk("rand_accepted", accepted, 10000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
